// File: rtl/manchester_rx.sv
// rtl/manchester_rx.sv - Manchester line receiver: start-symbol check, 8-bit MSB-first decode, IEEE/Thomas modes.
module manchester_rx #(
   parameter int HALF = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       mode,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       error,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

   localparam logic [7:0] PH_LAST   = 8'(HALF - 1);
   localparam logic [7:0] PH_SAMPLE = 8'(HALF / 2);
   localparam logic [4:0] K_LAST    = 5'd17;

   state_t     state, state_next;
   logic       sync1, rx_s, rx_prev;
   logic [1:0] fill;
   logic       rise;
   logic [7:0] ph, ph_next;
   logic [4:0] k, k_next;
   logic       first, first_next;
   logic       mode_l, mode_l_next;
   logic [7:0] shreg, shreg_next;
   logic [7:0] data_next;
   logic       valid_next, error_next;
   logic       sample;

   // fill blocks a false edge while the synchronizer refills after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         rx_s    <= 1'b0;
         rx_prev <= 1'b0;
         fill    <= 2'd0;
      end else begin
         sync1   <= rx_in;
         rx_s    <= sync1;
         rx_prev <= rx_s;
         if (fill != 2'd3) fill <= fill + 2'd1;
      end
   end

   assign rise   = rx_s && !rx_prev && (fill == 2'd3);
   assign sample = (ph == PH_SAMPLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ph         <= 8'd0;
         k          <= 5'd0;
         first      <= 1'b0;
         mode_l     <= 1'b0;
         shreg      <= 8'd0;
         data_out   <= 8'd0;
         data_valid <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_next;
         ph         <= ph_next;
         k          <= k_next;
         first      <= first_next;
         mode_l     <= mode_l_next;
         shreg      <= shreg_next;
         data_out   <= data_next;
         data_valid <= valid_next;
         error      <= error_next;
      end
   end

   always_comb begin
      state_next  = state;
      ph_next     = ph;
      k_next      = k;
      first_next  = first;
      mode_l_next = mode_l;
      shreg_next  = shreg;
      data_next   = data_out;
      valid_next  = 1'b0;
      error_next  = 1'b0;

      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_next  = START;
                  ph_next     = 8'd1;
                  k_next      = 5'd0;
                  mode_l_next = mode;
                  shreg_next  = 8'd0;
               end
            end
            START, DATA: begin
               if (ph == PH_LAST) begin
                  ph_next = 8'd0;
                  k_next  = k + 5'd1;
               end else begin
                  ph_next = ph + 8'd1;
               end
               // even samples hold the first half; odd samples complete a symbol
               if (sample) begin
                  if (!k[0]) begin
                     first_next = rx_s;
                  end else if (state == START) begin
                     if (first && !rx_s) begin
                        state_next = DATA;
                     end else begin
                        state_next = IDLE;
                        error_next = 1'b1;
                     end
                  end else if (first == rx_s) begin
                     state_next = IDLE;
                     error_next = 1'b1;
                  end else begin
                     shreg_next = {shreg[6:0], (mode_l ? rx_s : first)};
                     if (k == K_LAST) begin
                        state_next = DONE;
                        data_next  = shreg_next;
                        valid_next = 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_manchester_rx.sv
// tb/tb_manchester_rx.sv - scoreboard bench for manchester_rx with directed and random frames.
`timescale 1ns/1ps
module tb_manchester_rx;
   localparam int HALF = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       mode = 1'b0;
   logic       rx_in = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       error;
   logic       busy;

   manchester_rx #(.HALF(HALF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .mode       (mode),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .error      (error),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         at;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        e;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_dout = 8'h00;
   bit         final_req = 0;
   bit         final_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_dout = 8'h00;
         chk("reset_data_out", 32'(data_out), 32'h0);
         chk("reset_flags", 32'({data_valid, error, busy}), 32'h0);
      end else begin
         chk("valid_error_exclusive", 32'(data_valid & error), 32'h0);
         if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event: expected %s at cycle %0d", exp_q[0].is_err ? "error" : "data_valid", exp_q[0].at);
            void'(exp_q.pop_front());
         end
         if (data_valid || error) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: valid=%0b error=%0b at cycle %0d, want none", data_valid, error, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind_error", 32'(error), 32'(e.is_err));
               chk("event_cycle", 32'(cyc), 32'(e.at));
               if (!e.is_err) exp_dout = e.data;
            end
         end
         chk("data_out", 32'(data_out), 32'(exp_dout));
      end
      if (final_req && !final_done) begin
         final_done = 1;
         chk("pending_events", 32'(exp_q.size()), 32'h0);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1 rx_in = 1'b0;
      end
   endtask

   // Builds the half-bit level list from the encoding rules, then drives it HALF cycles per half.
   task automatic send_frame(input logic [7:0] b, input logic m, input int bad_bit, input logic bad_val,
                             input int toggle_at, input int abort_at, input bit abort_rst);
      logic lv[$];
      logic bv, fh;
      int   n, t, j, d;
      ev_t  ev;
      lv.push_back(1'b1);
      lv.push_back(1'b0);
      for (int s = 0; s < 8; s++) begin
         bv = b[7 - s];
         if ((7 - s) == bad_bit) begin
            lv.push_back(bad_val);
            lv.push_back(bad_val);
            break;
         end
         fh = m ? ~bv : bv;
         lv.push_back(fh);
         lv.push_back(~fh);
      end
      mode = m;
      t = 0;
      n = 0;
      for (int h = 0; h < lv.size(); h++) begin
         for (int c = 0; c < HALF; c++) begin
            @(posedge clk);
            #1;
            if (t == 0) begin
               n = cyc;
               d = n + 2;
               if (abort_at < 0) begin
                  ev.data = b;
                  if (bad_bit >= 0) begin
                     j = 7 - bad_bit;
                     ev.is_err = 1;
                     ev.at = d + (2 * j + 3) * HALF + HALF / 2 + 1;
                  end else begin
                     ev.is_err = 0;
                     ev.at = d + 17 * HALF + HALF / 2 + 1;
                  end
                  exp_q.push_back(ev);
               end
            end
            if (t == abort_at) begin
               rx_in = 1'b0;
               if (abort_rst) rst_n = 1'b0;
               else enable = 1'b0;
               return;
            end
            if (t == toggle_at) mode = ~mode;
            rx_in = lv[h];
            t++;
         end
      end
   endtask

   task automatic glitch();
      ev_t ev;
      @(posedge clk);
      #1;
      rx_in = 1'b1;
      ev.is_err = 1;
      ev.data = 8'h00;
      ev.at = cyc + 2 + HALF + HALF / 2 + 1;
      exp_q.push_back(ev);
      idle(2 * HALF + 6);
   endtask

   initial begin
      int   bad;
      int   gap;
      logic [7:0] rb;
      logic rm, rv;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      enable = 1'b1;
      idle(5);

      send_frame(8'hA5, 1'b0, -1, 1'b0, -1, -1, 0);
      idle(3);
      send_frame(8'h3C, 1'b1, -1, 1'b0, 22, -1, 0);
      idle(3);
      send_frame(8'hF0, 1'b0, 3, 1'b1, -1, -1, 0);
      idle(4);
      glitch();
      send_frame(8'h12, 1'b0, -1, 1'b0, -1, -1, 0);
      idle(2);
      send_frame(8'h34, 1'b0, -1, 1'b0, -1, -1, 0);
      idle(3);

      send_frame(8'h55, 1'b0, -1, 1'b0, -1, 30, 0);
      idle(4);
      enable = 1'b1;
      idle(4);

      send_frame(8'h66, 1'b1, -1, 1'b0, -1, 32, 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(6);
      send_frame(8'h81, 1'b0, -1, 1'b0, -1, -1, 0);
      idle(3);

      for (int i = 0; i < 24; i++) begin
         rb  = 8'($urandom);
         rm  = 1'($urandom_range(0, 1));
         rv  = 1'($urandom_range(0, 1));
         bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
         gap = int'($urandom_range(2, 6));
         send_frame(rb, rm, bad, rv, int'($urandom_range(3, 17 * HALF)), -1, 0);
         idle(gap);
      end

      idle(100);
      final_req = 1;
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
